// File: rtl/regmodel0_fdbs0_fdb_ring_engine.sv
// fdbs0 doorbell ring engine: queues accepted rings and feeds the
// hardware consumer while reporting FIFO-derived fields to the register block.
module regmodel0_fdbs0_fdb_ring_engine #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  reqinfo,
  input  logic [1:0]  cnt_din,
  input  logic        cnt_w,
  input  logic        cnt_r,
  output logic [1:0]  cnt_qout,
  input  logic        failed_ring_q,
  output logic        failed_ring_d,
  output logic        failed_ring_enb,
  input  logic [1:0]  max_priority_q,
  output logic [1:0]  max_priority_d,
  output logic        max_priority_enb,
  input  logic [4:0]  valid_fcnt_q,
  output logic [4:0]  valid_fcnt_d,
  output logic        valid_fcnt_enb,
  input  logic [4:0]  fcnt_q,
  output logic [4:0]  fcnt_d,
  output logic        fcnt_enb,
  input  logic        ack_on_empty_q,
  input  logic [15:0] enable_din,
  input  logic        enable_w,
  output logic [15:0] enable_qout,
  output logic [15:0] status_d,
  input  logic [31:0] din,
  input  logic [1:0]  a,
  input  logic [31:0] wen,
  input  logic        cen,
  output logic [31:0] dout,
  output logic        ring_valid,
  input  logic        ring_ready,
  output logic [31:0] ring_data,
  output logic [3:0]  ring_src,
  output logic [1:0]  ring_prio
);

  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    src_mem  [DEPTH];
  logic [1:0]    prio_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [31:0]   staging;
  logic [15:0]   enable;
  logic          fail_q;
  logic [31:0]   dout_q;

  logic          full;
  logic          pop;
  logic          push;
  logic          fail;
  logic          rd;
  logic          stg_wr;
  logic          rd_hit;
  logic [AW-1:0] rd_idx;
  logic [3:0]    src;

  logic [AW-1:0] off;
  logic [1:0]    max_prio;
  logic [4:0]    vcnt;
  logic [15:0]   status;

  logic          unused;
  assign unused = ^{reqinfo[5:4], failed_ring_q};

  assign src        = reqinfo[3:0];
  assign ring_valid = (count != '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign pop        = ring_valid & (ring_ready | cnt_r);
  assign push       = cnt_w & enable[src] & (~full | pop);
  // Empty pops only count as a failure when software asked for strictness.
  assign fail       = (cnt_w & ~push)
                    | (cnt_r & ~ring_valid & ~ack_on_empty_q);

  assign rd     = cen & (wen == '0);
  assign stg_wr = cen & (wen != '0) & (a == 2'd0);
  assign rd_hit = ((AW+1)'(a) < count);
  assign rd_idx = head + AW'(a);

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      staging <= '0;
      enable  <= '0;
      fail_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      fail_q <= fail;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stg_wr) staging <= (staging & ~wen) | (din & wen);
      if (enable_w) enable <= enable_din;
      if (rd) dout_q <= rd_hit ? data_mem[rd_idx] : '0;
    end
  end

  // Storage needs no reset: occupancy is governed by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail] <= staging;
      src_mem[tail]  <= src;
      prio_mem[tail] <= cnt_din;
    end
  end

  always_comb begin
    off      = '0;
    max_prio = '0;
    vcnt     = '0;
    status   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = AW'(j) - head;
      if ({1'b0, off} < count) begin
        status[src_mem[j]] = 1'b1;
        if (enable[src_mem[j]]) vcnt = vcnt + 5'd1;
        if (prio_mem[j] > max_prio) max_prio = prio_mem[j];
      end
    end
  end

  assign ring_data = data_mem[head];
  assign ring_src  = src_mem[head];
  assign ring_prio = prio_mem[head];
  assign cnt_qout  = ring_valid ? ring_prio : 2'd0;

  assign enable_qout = enable;
  assign status_d    = status;
  assign dout        = dout_q;

  assign failed_ring_d   = fail_q;
  assign failed_ring_enb = fail_q;

  assign max_priority_d   = max_prio;
  assign max_priority_enb = (max_prio != max_priority_q);
  assign valid_fcnt_d     = vcnt;
  assign valid_fcnt_enb   = (vcnt != valid_fcnt_q);
  assign fcnt_d           = 5'(count);
  assign fcnt_enb         = (fcnt_d != fcnt_q);

endmodule

// File: tb/tb_regmodel0_fdbs0_fdb_ring_engine.sv
// Directed bench for the fdbs0 ring engine with a small register-block
// model that latches each field on its update strobe.
module tb_regmodel0_fdbs0_fdb_ring_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  reqinfo;
  logic [1:0]  cnt_din;
  logic        cnt_w;
  logic        cnt_r;
  logic [1:0]  cnt_qout;
  logic        failed_ring_q;
  logic        failed_ring_d;
  logic        failed_ring_enb;
  logic [1:0]  max_priority_q;
  logic [1:0]  max_priority_d;
  logic        max_priority_enb;
  logic [4:0]  valid_fcnt_q;
  logic [4:0]  valid_fcnt_d;
  logic        valid_fcnt_enb;
  logic [4:0]  fcnt_q;
  logic [4:0]  fcnt_d;
  logic        fcnt_enb;
  logic        ack_on_empty_q;
  logic [15:0] enable_din;
  logic        enable_w;
  logic [15:0] enable_qout;
  logic [15:0] status_d;
  logic [31:0] din;
  logic [1:0]  a;
  logic [31:0] wen;
  logic        cen;
  logic [31:0] dout;
  logic        ring_valid;
  logic        ring_ready;
  logic [31:0] ring_data;
  logic [3:0]  ring_src;
  logic [1:0]  ring_prio;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regmodel0_fdbs0_fdb_ring_engine dut (
    .clk(clk), .reset(reset), .reqinfo(reqinfo), .cnt_din(cnt_din),
    .cnt_w(cnt_w), .cnt_r(cnt_r), .cnt_qout(cnt_qout),
    .failed_ring_q(failed_ring_q), .failed_ring_d(failed_ring_d),
    .failed_ring_enb(failed_ring_enb),
    .max_priority_q(max_priority_q), .max_priority_d(max_priority_d),
    .max_priority_enb(max_priority_enb),
    .valid_fcnt_q(valid_fcnt_q), .valid_fcnt_d(valid_fcnt_d),
    .valid_fcnt_enb(valid_fcnt_enb),
    .fcnt_q(fcnt_q), .fcnt_d(fcnt_d), .fcnt_enb(fcnt_enb),
    .ack_on_empty_q(ack_on_empty_q),
    .enable_din(enable_din), .enable_w(enable_w), .enable_qout(enable_qout),
    .status_d(status_d), .din(din), .a(a), .wen(wen), .cen(cen),
    .dout(dout), .ring_valid(ring_valid), .ring_ready(ring_ready),
    .ring_data(ring_data), .ring_src(ring_src), .ring_prio(ring_prio)
  );

  // Register block: fields follow their update strobes.
  always @(posedge clk) begin
    if (reset) begin
      failed_ring_q  <= 1'b0;
      max_priority_q <= '0;
      valid_fcnt_q   <= '0;
      fcnt_q         <= '0;
    end else begin
      if (failed_ring_enb)  failed_ring_q  <= failed_ring_d;
      if (max_priority_enb) max_priority_q <= max_priority_d;
      if (valid_fcnt_enb)   valid_fcnt_q   <= valid_fcnt_d;
      if (fcnt_enb)         fcnt_q         <= fcnt_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stage(input logic [31:0] d, input logic [31:0] m,
                       input logic [1:0] ad);
    cen = 1'b1; din = d; wen = m; a = ad;
    tick();
    cen = 1'b0; wen = '0; a = '0;
  endtask

  task automatic ring(input logic [3:0] s, input logic [1:0] p);
    reqinfo = {2'b11, s}; cnt_din = p; cnt_w = 1'b1;
    tick();
    cnt_w = 1'b0;
  endtask

  task automatic set_enable(input logic [15:0] m);
    enable_din = m; enable_w = 1'b1;
    tick();
    enable_w = 1'b0;
  endtask

  task automatic read_win(input logic [1:0] ad);
    cen = 1'b1; wen = '0; a = ad;
    tick();
    cen = 1'b0; a = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (fcnt_d !== 5'd0) begin n_err++;
      $display("FAIL rst_fcnt: got %0d want 0", fcnt_d); end
    n_cmp++; if (ring_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_valid: got %b want 0", ring_valid); end
    n_cmp++; if (enable_qout !== 16'h0) begin n_err++;
      $display("FAIL rst_enable: got %h want 0000", enable_qout); end
    n_cmp++; if (dout !== 32'h0) begin n_err++;
      $display("FAIL rst_dout: got %h want 0", dout); end
    n_cmp++; if ({failed_ring_d, failed_ring_enb} !== 2'b00) begin n_err++;
      $display("FAIL rst_failed: got %b want 00",
               {failed_ring_d, failed_ring_enb}); end
    n_cmp++; if ({status_d, max_priority_d, valid_fcnt_d, cnt_qout} !== '0)
      begin n_err++;
      $display("FAIL rst_fields: got st=%h mp=%0d vf=%0d q=%0d want 0",
               status_d, max_priority_d, valid_fcnt_d, cnt_qout); end
  endtask

  task automatic test_basic_ring();
    set_enable(16'h0001);
    stage(32'hDEADBEEF, 32'hFFFFFFFF, 2'd0);
    reqinfo = 6'd0; cnt_din = 2'd2; cnt_w = 1'b1;
    tick();
    cnt_w = 1'b0;
    n_cmp++; if ({fcnt_d, fcnt_enb} !== {5'd1, 1'b1}) begin n_err++;
      $display("FAIL basic_fcnt: got %0d/%b want 1/1", fcnt_d, fcnt_enb); end
    n_cmp++; if (max_priority_d !== 2'd2) begin n_err++;
      $display("FAIL basic_maxp: got %0d want 2", max_priority_d); end
    n_cmp++; if (status_d !== 16'h0001) begin n_err++;
      $display("FAIL basic_status: got %h want 0001", status_d); end
    n_cmp++; if ({ring_valid, ring_data} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL basic_head: got %b/%h want 1/deadbeef",
               ring_valid, ring_data); end
    n_cmp++; if ({ring_prio, cnt_qout, ring_src} !== {2'd2, 2'd2, 4'd0})
      begin n_err++;
      $display("FAIL basic_prio: got %0d/%0d/%0d want 2/2/0",
               ring_prio, cnt_qout, ring_src); end
    cnt_r = 1'b1;
    tick();
    cnt_r = 1'b0;
    n_cmp++; if ({fcnt_d, ring_valid, failed_ring_d} !== {5'd0, 1'b0, 1'b0})
      begin n_err++;
      $display("FAIL basic_pop: got %0d/%b/%b want 0/0/0",
               fcnt_d, ring_valid, failed_ring_d); end
  endtask

  task automatic test_reject();
    ring(4'd3, 2'd1);
    n_cmp++; if ({failed_ring_d, failed_ring_enb} !== 2'b11) begin n_err++;
      $display("FAIL rej_pulse: got %b want 11",
               {failed_ring_d, failed_ring_enb}); end
    n_cmp++; if ({fcnt_d, fcnt_enb, max_priority_enb, valid_fcnt_enb}
                 !== {5'd0, 3'b000}) begin n_err++;
      $display("FAIL rej_fields: got %0d/%b%b%b want 0/000", fcnt_d,
               fcnt_enb, max_priority_enb, valid_fcnt_enb); end
    tick();
    n_cmp++; if (failed_ring_enb !== 1'b0) begin n_err++;
      $display("FAIL rej_once: got %b want 0", failed_ring_enb); end
  endtask

  task automatic test_full_wrap();
    set_enable(16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      stage(32'h1000_0000 + 32'(i), 32'hFFFFFFFF, 2'd0);
      ring(4'(i), 2'(i % 4));
    end
    n_cmp++; if ({fcnt_d, valid_fcnt_d} !== {5'd16, 5'd16}) begin n_err++;
      $display("FAIL full_cnt: got %0d/%0d want 16/16",
               fcnt_d, valid_fcnt_d); end
    n_cmp++; if ({status_d, max_priority_d} !== {16'hFFFF, 2'd3}) begin
      n_err++;
      $display("FAIL full_fields: got %h/%0d want ffff/3",
               status_d, max_priority_d); end
    stage(32'h1000_0010, 32'hFFFFFFFF, 2'd0);
    ring_ready = 1'b0;
    ring(4'd5, 2'd1);
    n_cmp++; if ({failed_ring_d, fcnt_d} !== {1'b1, 5'd16}) begin n_err++;
      $display("FAIL full_rej: got %b/%0d want 1/16",
               failed_ring_d, fcnt_d); end
    ring_ready = 1'b1;
    ring(4'd5, 2'd1);
    ring_ready = 1'b0;
    n_cmp++; if ({fcnt_d, failed_ring_d} !== {5'd16, 1'b0}) begin n_err++;
      $display("FAIL full_pp: got %0d/%b want 16/0", fcnt_d, failed_ring_d);
      end
    n_cmp++; if ({ring_data, ring_src} !== {32'h1000_0001, 4'd1}) begin
      n_err++;
      $display("FAIL full_head: got %h/%0d want 10000001/1",
               ring_data, ring_src); end
    ring_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if ({ring_valid, ring_data} !== {1'b1, 32'h1000_0000 + 32'(k)})
        begin n_err++;
        $display("FAIL drain_%0d: got %b/%h want 1/%h", k, ring_valid,
                 ring_data, 32'h1000_0000 + 32'(k)); end
      tick();
    end
    ring_ready = 1'b0;
    n_cmp++; if ({ring_valid, fcnt_d} !== {1'b0, 5'd0}) begin n_err++;
      $display("FAIL drain_end: got %b/%0d want 0/0", ring_valid, fcnt_d);
      end
  endtask

  task automatic test_empty_pop();
    ack_on_empty_q = 1'b0;
    cnt_r = 1'b1;
    tick();
    cnt_r = 1'b0;
    n_cmp++; if ({failed_ring_d, failed_ring_enb} !== 2'b11) begin n_err++;
      $display("FAIL empty_nak: got %b want 11",
               {failed_ring_d, failed_ring_enb}); end
    tick();
    ack_on_empty_q = 1'b1;
    cnt_r = 1'b1;
    tick();
    cnt_r = 1'b0;
    n_cmp++; if ({failed_ring_enb, fcnt_d} !== {1'b0, 5'd0}) begin n_err++;
      $display("FAIL empty_ack: got %b/%0d want 0/0", failed_ring_enb,
               fcnt_d); end
    ack_on_empty_q = 1'b0;
  endtask

  task automatic test_staging_window();
    stage(32'hAAAAAAAA, 32'hFFFFFFFF, 2'd0);
    stage(32'h12345678, 32'h0000FFFF, 2'd0);
    ring(4'd1, 2'd1);
    stage(32'h55555555, 32'hFFFFFFFF, 2'd0);
    ring(4'd2, 2'd0);
    n_cmp++; if ({ring_data, ring_src} !== {32'hAAAA5678, 4'd1}) begin
      n_err++;
      $display("FAIL stg_merge: got %h/%0d want aaaa5678/1",
               ring_data, ring_src); end
    n_cmp++; if ({status_d, max_priority_d} !== {16'h0006, 2'd1}) begin
      n_err++;
      $display("FAIL stg_fields: got %h/%0d want 0006/1",
               status_d, max_priority_d); end
    read_win(2'd1);
    n_cmp++; if (dout !== 32'h55555555) begin n_err++;
      $display("FAIL win_a1: got %h want 55555555", dout); end
    read_win(2'd2);
    n_cmp++; if (dout !== 32'h0) begin n_err++;
      $display("FAIL win_a2: got %h want 0", dout); end
    read_win(2'd0);
    n_cmp++; if (dout !== 32'hAAAA5678) begin n_err++;
      $display("FAIL win_a0: got %h want aaaa5678", dout); end
    tick();
    n_cmp++; if (dout !== 32'hAAAA5678) begin n_err++;
      $display("FAIL win_hold: got %h want aaaa5678", dout); end
    stage(32'h0, 32'hFFFFFFFF, 2'd1);
    ring(4'd3, 2'd0);
    read_win(2'd2);
    n_cmp++; if (dout !== 32'h55555555) begin n_err++;
      $display("FAIL stg_ign: got %h want 55555555", dout); end
  endtask

  task automatic test_disable_reset();
    ring(4'd4, 2'd0);
    ring(4'd5, 2'd3);
    n_cmp++; if ({valid_fcnt_d, max_priority_d} !== {5'd5, 2'd3}) begin
      n_err++;
      $display("FAIL dis_pre: got %0d/%0d want 5/3", valid_fcnt_d,
               max_priority_d); end
    set_enable(16'h0000);
    n_cmp++; if ({valid_fcnt_d, fcnt_d} !== {5'd0, 5'd5}) begin n_err++;
      $display("FAIL dis_cnt: got %0d/%0d want 0/5", valid_fcnt_d, fcnt_d);
      end
    n_cmp++; if (status_d !== 16'h003E) begin n_err++;
      $display("FAIL dis_status: got %h want 003e", status_d); end
    enable_din = 16'hFFFF; enable_w = 1'b1;
    reqinfo = 6'd6; cnt_w = 1'b1; ring_ready = 1'b1;
    cen = 1'b1; din = 32'h1; wen = 32'hFFFFFFFF; a = 2'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0; enable_w = 1'b0; cnt_w = 1'b0; ring_ready = 1'b0;
    cen = 1'b0; wen = '0;
    n_cmp++; if ({fcnt_d, ring_valid, status_d, enable_qout, dout}
                 !== '0) begin n_err++;
      $display("FAIL mid_rst: got %0d/%b/%h/%h/%h want all 0", fcnt_d,
               ring_valid, status_d, enable_qout, dout); end
    n_cmp++; if ({failed_ring_d, max_priority_d, valid_fcnt_d} !== '0)
      begin n_err++;
      $display("FAIL mid_rst_f: got %b/%0d/%0d want 0", failed_ring_d,
               max_priority_d, valid_fcnt_d); end
    set_enable(16'h0001);
    ring(4'd0, 2'd1);
    n_cmp++; if ({fcnt_d, ring_data} !== {5'd1, 32'h0}) begin n_err++;
      $display("FAIL post_rst: got %0d/%h want 1/0", fcnt_d, ring_data); end
  endtask

  initial begin
    reset = 1'b1; reqinfo = '0; cnt_din = '0; cnt_w = 1'b0; cnt_r = 1'b0;
    ack_on_empty_q = 1'b0; enable_din = '0; enable_w = 1'b0;
    din = '0; a = '0; wen = '0; cen = 1'b0; ring_ready = 1'b0;
    test_reset();
    test_basic_ring();
    test_reject();
    test_full_wrap();
    test_empty_pop();
    test_staging_window();
    test_disable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
